// File: rtl/regbank_bypass.sv
// -----------------------------------------------------------------------------
// regbank_bypass
//
// Write-back and operand-source block for the 8-bit MIPS pipeline.
//
// This block holds the register bank. The data-memory stage writes back into
// the bank. For the instruction in decode, the block reads two operands and
// forwards newer in-flight results from the EX and DM stages. It then
// registers the selected operands into the EX stage.
//
// A load in EX produces only an address, so its result cannot be forwarded
// yet. When a decode operand depends on it, hazard_id is raised and the
// operand registers hold.
//
// Ports
//   clk         in   clock, all state updates on the rising edge
//   reset       in   synchronous active-high reset (clears bank and outputs)
//   mux_ans_dm  in   DW   write-back data leaving the data-memory stage
//   RW_dm       in   5    write-back destination, 0 = no write
//   ans_ex      in   DW   ALU result of the instruction in EX
//   RW_ex       in   5    destination of the instruction in EX, 0 = none
//   load_ex     in   1    instruction in EX is a load
//   RA_id       in   5    operand A source register (decode)
//   RB_id       in   5    operand B source register (decode)
//   stall_id    in   1    external hold of the decode-to-EX register
//   A_Bypass    out  DW   registered operand A
//   B_Bypass    out  DW   registered operand B (ALU operand / store data)
//   hazard_id   out  1    combinational load-use hazard request
// -----------------------------------------------------------------------------
module regbank_bypass #(
    parameter int NREG = 32,
    parameter int DW   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DW-1:0]             mux_ans_dm,
    input  logic [$clog2(NREG)-1:0]   RW_dm,
    input  logic [DW-1:0]             ans_ex,
    input  logic [$clog2(NREG)-1:0]   RW_ex,
    input  logic                      load_ex,
    input  logic [$clog2(NREG)-1:0]   RA_id,
    input  logic [$clog2(NREG)-1:0]   RB_id,
    input  logic                      stall_id,
    output logic [DW-1:0]             A_Bypass,
    output logic [DW-1:0]             B_Bypass,
    output logic                      hazard_id
);

    localparam int AW = $clog2(NREG);

    logic [DW-1:0]   bank_reg [NREG];
    logic [NREG-1:0] wr_en;
    logic [DW-1:0]   a_sel;
    logic [DW-1:0]   b_sel;
    logic [DW-1:0]   a_bypass_reg;
    logic [DW-1:0]   b_bypass_reg;

    // Per-register write decode. Register 0 is never written, so its entry
    // stays at the reset value of zero.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_wr_dec
            if (gi == 0) begin : g_r0
                assign wr_en[gi] = 1'b0;
            end else begin : g_rn
                assign wr_en[gi] = (RW_dm == AW'(gi));
            end
        end
    endgenerate

    // Write-back does not depend on stall or hazard. Only reset blocks it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                bank_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_en[i]) begin
                    bank_reg[i] <= mux_ans_dm;
                end
            end
        end
    end

    // Operand source selection, from highest to lowest priority:
    //   1. R0 reads as zero.
    //   2. The EX result, unless it is a load address.
    //   3. The DM write-back value. This also covers a same-cycle
    //      read and write of one register.
    //   4. The bank.
    function automatic logic [DW-1:0] select_operand(
        input logic [AW-1:0] rx,
        input logic [AW-1:0] rw_ex_i,
        input logic          load_ex_i,
        input logic [DW-1:0] ans_ex_i,
        input logic [AW-1:0] rw_dm_i,
        input logic [DW-1:0] ans_dm_i,
        input logic [DW-1:0] bank_val
    );
        logic [DW-1:0] res;
        if (rx == '0) begin
            res = '0;
        end else if ((rx == rw_ex_i) && !load_ex_i) begin
            res = ans_ex_i;
        end else if (rx == rw_dm_i) begin
            res = ans_dm_i;
        end else begin
            res = bank_val;
        end
        return res;
    endfunction

    always_comb begin
        a_sel = select_operand(RA_id, RW_ex, load_ex, ans_ex, RW_dm, mux_ans_dm,
                               bank_reg[RA_id]);
        b_sel = select_operand(RB_id, RW_ex, load_ex, ans_ex, RW_dm, mux_ans_dm,
                               bank_reg[RB_id]);
    end

    // A load in EX cannot forward data yet. Any decode operand that names
    // its destination must wait until the load reaches DM.
    assign hazard_id = load_ex && (RW_ex != '0) &&
                       ((RA_id == RW_ex) || (RB_id == RW_ex));

    always_ff @(posedge clk) begin
        if (reset) begin
            a_bypass_reg <= '0;
            b_bypass_reg <= '0;
        end else if (!(stall_id || hazard_id)) begin
            a_bypass_reg <= a_sel;
            b_bypass_reg <= b_sel;
        end
    end

    assign A_Bypass = a_bypass_reg;
    assign B_Bypass = b_bypass_reg;

endmodule

// File: tb/tb_regbank_bypass.sv
// -----------------------------------------------------------------------------
// tb_regbank_bypass
//
// Directed-vector bench for regbank_bypass.
//
// The driver applies one vector per clock cycle. For each vector it queues
// the hand-computed values that A_Bypass and B_Bypass should hold after the
// edge. It also queues the value hazard_id should show during that cycle.
//
// A separate monitor samples hazard_id mid-cycle. Just after each rising
// edge, the monitor pops one entry and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_regbank_bypass;

    logic       clk;
    logic       reset;
    logic [7:0] mux_ans_dm;
    logic [4:0] RW_dm;
    logic [7:0] ans_ex;
    logic [4:0] RW_ex;
    logic       load_ex;
    logic [4:0] RA_id;
    logic [4:0] RB_id;
    logic       stall_id;
    logic [7:0] A_Bypass;
    logic [7:0] B_Bypass;
    logic       hazard_id;

    regbank_bypass #(.NREG(32), .DW(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .mux_ans_dm (mux_ans_dm),
        .RW_dm      (RW_dm),
        .ans_ex     (ans_ex),
        .RW_ex      (RW_ex),
        .load_ex    (load_ex),
        .RA_id      (RA_id),
        .RB_id      (RB_id),
        .stall_id   (stall_id),
        .A_Bypass   (A_Bypass),
        .B_Bypass   (B_Bypass),
        .hazard_id  (hazard_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: the queues below are pushed and popped together.
    logic [7:0] q_a   [$];
    logic [7:0] q_b   [$];
    logic       q_h   [$];
    bit         q_chk [$];
    string      q_name[$];

    int   tests_run = 0;
    int   tests_failed = 0;
    logic haz_sample;

    task automatic check8(input string name, input string what,
                          input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s %s: got %02h, expected %02h", name, what, act, exp);
        end
    endtask

    // Hazard is combinational. Sample it mid-cycle, once the driven inputs
    // have settled.
    initial begin
        forever begin
            @(negedge clk);
            haz_sample = hazard_id;
        end
    end

    // Monitor: each entry describes the cycle that has just ended.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() > 0) begin
                logic [7:0] ea;
                logic [7:0] eb;
                logic       eh;
                bit         ck;
                string      nm;
                ea = q_a.pop_front();
                eb = q_b.pop_front();
                eh = q_h.pop_front();
                ck = q_chk.pop_front();
                nm = q_name.pop_front();
                if (ck) begin
                    check8(nm, "A_Bypass", A_Bypass, ea);
                    check8(nm, "B_Bypass", B_Bypass, eb);
                    tests_run++;
                    if (haz_sample !== eh) begin
                        tests_failed++;
                        $display("[TB] FAIL %s hazard_id: got %0b, expected %0b",
                                 nm, haz_sample, eh);
                    end
                    $display("[TB] %-14s A=%02h B=%02h hz=%0b (exp %02h %02h %0b)",
                             nm, A_Bypass, B_Bypass, haz_sample, ea, eb, eh);
                end
            end
        end
    end

    // Apply one vector for the coming edge and queue its expected results.
    task automatic step(input string name, input logic rst,
                        input logic [7:0] dm, input logic [4:0] rwdm,
                        input logic [7:0] ex, input logic [4:0] rwex,
                        input logic ld, input logic [4:0] ra,
                        input logic [4:0] rb, input logic st,
                        input logic [7:0] ea, input logic [7:0] eb,
                        input logic eh);
        @(posedge clk);
        #2;
        reset      = rst;
        mux_ans_dm = dm;
        RW_dm      = rwdm;
        ans_ex     = ex;
        RW_ex      = rwex;
        load_ex    = ld;
        RA_id      = ra;
        RB_id      = rb;
        stall_id   = st;
        q_a.push_back(ea);
        q_b.push_back(eb);
        q_h.push_back(eh);
        q_chk.push_back(1'b1);
        q_name.push_back(name);
    endtask

    initial begin
        reset = 1'b1; mux_ans_dm = '0; RW_dm = '0; ans_ex = '0; RW_ex = '0;
        load_ex = 1'b0; RA_id = '0; RB_id = '0; stall_id = 1'b0;

        //    name            rst dm     rwdm   ex     rwex   ld ra     rb     st  expA   expB   hz
        step("reset_init",    1, 8'h00, 5'd0,  8'h00, 5'd0,  0, 5'd0,  5'd0,  0, 8'h00, 8'h00, 0);
        step("fill_r5",       0, 8'hAA, 5'd5,  8'h00, 5'd0,  0, 5'd0,  5'd0,  0, 8'h00, 8'h00, 0);
        step("read_r5_pre",   0, 8'h00, 5'd0,  8'h00, 5'd0,  0, 5'd5,  5'd5,  0, 8'hAA, 8'hAA, 0);
        // Reset wins over hazard. hazard_id still reflects its inputs.
        step("reset_hazard",  1, 8'h00, 5'd0,  8'h40, 5'd7,  1, 5'd7,  5'd5,  0, 8'h00, 8'h00, 1);
        step("read_r5_post",  0, 8'h00, 5'd0,  8'h00, 5'd0,  0, 5'd5,  5'd5,  0, 8'h00, 8'h00, 0);
        step("wr_r31",        0, 8'h50, 5'd31, 8'h00, 5'd0,  0, 5'd0,  5'd0,  0, 8'h00, 8'h00, 0);
        step("rd_r31",        0, 8'h00, 5'd0,  8'h00, 5'd0,  0, 5'd31, 5'd0,  0, 8'h50, 8'h00, 0);
        step("r0_bypass",     0, 8'hFF, 5'd0,  8'h00, 5'd0,  0, 5'd0,  5'd0,  0, 8'h00, 8'h00, 0);
        step("r0_bank",       0, 8'h00, 5'd0,  8'h00, 5'd0,  0, 5'd0,  5'd0,  0, 8'h00, 8'h00, 0);
        step("fill_r3",       0, 8'h11, 5'd3,  8'h00, 5'd0,  0, 5'd0,  5'd0,  0, 8'h00, 8'h00, 0);
        step("fwd_ex_wins",   0, 8'h22, 5'd3,  8'h05, 5'd3,  0, 5'd3,  5'd3,  0, 8'h05, 8'h05, 0);
        step("refill_r3",     0, 8'h11, 5'd3,  8'h00, 5'd0,  0, 5'd0,  5'd0,  0, 8'h00, 8'h00, 0);
        step("fwd_dm",        0, 8'h22, 5'd3,  8'h05, 5'd0,  0, 5'd3,  5'd0,  0, 8'h22, 8'h00, 0);
        step("bank_r3",       0, 8'h00, 5'd0,  8'h00, 5'd0,  0, 5'd3,  5'd0,  0, 8'h22, 8'h00, 0);
        // Load-use: outputs hold and the load address is not forwarded.
        step("ld_use_hold",   0, 8'h00, 5'd0,  8'h40, 5'd7,  1, 5'd0,  5'd7,  0, 8'h22, 8'h00, 1);
        step("ld_use_dm",     0, 8'h3C, 5'd7,  8'h00, 5'd0,  0, 5'd0,  5'd7,  0, 8'h00, 8'h3C, 0);
        step("pre_stall",     0, 8'h00, 5'd0,  8'h00, 5'd0,  0, 5'd31, 5'd7,  0, 8'h50, 8'h3C, 0);
        step("stall_wr",      0, 8'h99, 5'd4,  8'h00, 5'd0,  0, 5'd4,  5'd4,  1, 8'h50, 8'h3C, 0);
        step("stall_hold",    0, 8'h00, 5'd0,  8'h00, 5'd0,  0, 5'd4,  5'd4,  1, 8'h50, 8'h3C, 0);
        step("post_stall",    0, 8'h00, 5'd0,  8'h00, 5'd0,  0, 5'd4,  5'd4,  0, 8'h99, 8'h99, 0);
        step("same_src_ex",   0, 8'h00, 5'd0,  8'hA5, 5'd5,  0, 5'd5,  5'd5,  0, 8'hA5, 8'hA5, 0);
        step("haz_ra",        0, 8'h00, 5'd0,  8'h40, 5'd9,  1, 5'd9,  5'd0,  0, 8'hA5, 8'hA5, 1);
        step("haz_rw0",       0, 8'h00, 5'd0,  8'h40, 5'd0,  1, 5'd0,  5'd0,  0, 8'h00, 8'h00, 0);
        step("idle",          0, 8'h00, 5'd0,  8'h00, 5'd0,  0, 5'd4,  5'd31, 0, 8'h99, 8'h50, 0);

        // Drain the scoreboard, with a bounded wait.
        for (int i = 0; i < 10 && q_a.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (q_a.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", q_a.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regbank_bypass.md
# regbank_bypass

Write-back and operand-source block for the 8-bit MIPS pipeline: the consuming end of the data-memory stage's result interface (`mux_ans_dm`/`RW_dm`) and the producing end of its store-data input (`B_Bypass`). It holds the 32x8 register bank, which is written from the data-memory stage. It reads two operands for the instruction in decode and forwards newer in-flight results from the EX and DM stages. It registers the selected operands into the EX stage and flags load-use hazards.

## Interface
Parameters:
- `NREG`, 32: number of registers; register 0 hardwired to 8'h00.
- `DW`, 8: data width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; sampled on rising edge of `clk`.
- `mux_ans_dm`  in  8  result leaving the data-memory stage (write-back data).
- `RW_dm`  in  5  destination register of `mux_ans_dm`; 0 = no write.
- `ans_ex`  in  8  ALU result of the instruction currently in EX.
- `RW_ex`  in  5  destination of the instruction in EX; 0 = none.
- `load_ex`  in  1  instruction in EX is a load (`ans_ex` is an address, not data).
- `RA_id`  in  5  operand A source register of the instruction in decode.
- `RB_id`  in  5  operand B source register of the instruction in decode.
- `stall_id`  in  1  external hold of the decode-to-EX register.
- `A_Bypass`  out  8  registered operand A to EX.
- `B_Bypass`  out  8  registered operand B to EX (ALU operand and store data).
- `hazard_id`  out  1  combinational load-use hazard request to the pipeline control.

## Operation
- Register bank: `bank[1..31]`, 8 bits each. `bank[0]` always reads 8'h00 and is never written.
- Write-back:
  - Each rising edge with `reset`=0 and `RW_dm`!=0 does `bank[RW_dm] <= mux_ans_dm`.
  - Write-back is independent of `stall_id` and `hazard_id`.
- Operand select, per operand X in {A,B} with source `RX_id`, in priority order:
  1. `RX_id`==0 -> 8'h00.
  2. `RX_id`==`RW_ex` and `load_ex`=0 -> `ans_ex`.
  3. `RX_id`==`RW_dm` -> `mux_ans_dm`.
  4. Otherwise -> `bank[RX_id]`.
- Because of rule 3, a read and a write to the same register in the same cycle returns the new value.
- Hazard: `hazard_id` = `load_ex` & (`RW_ex`!=0) & ((`RA_id`==`RW_ex`) | (`RB_id`==`RW_ex`)).
- Output register update on each edge:
  - `reset`=1: `A_Bypass`, `B_Bypass` <= 8'h00, and all `bank` entries <= 8'h00.
  - else if `stall_id`=1 or `hazard_id`=1: `A_Bypass`, `B_Bypass` hold.
  - else: `A_Bypass`, `B_Bypass` <= selected values.
- No other state. Widths are exact 8-bit and 5-bit; there is no arithmetic and no wrap.

## Timing
- Reset values: `A_Bypass`=8'h00, `B_Bypass`=8'h00, `bank[*]`=8'h00.
  - `hazard_id` is combinational from inputs only, so it can be 1 during reset if inputs request it.
- Reset is synchronous: asserting it mid-stream clears everything at the next edge, including a write-back presented on that edge. Reset wins over write, stall and hazard.
- Latency:
  - Decode operands to `A_Bypass`/`B_Bypass`: 1 cycle.
  - Write-back to bank-visible: value is readable from the bank from the next cycle. It is visible through the bypass in the same cycle.
- Load-use: `hazard_id` holds the outputs for as long as the load sits in EX.
  - The control inserts one bubble.
  - The next cycle the load is in DM, and rule 3 supplies `mux_ans_dm`.
- Simultaneous cases:
  - EX and DM target the same register: EX wins.
  - `RA_id`==`RB_id`: both outputs get the same value.
  - `stall_id` with a write-back: the write still happens.

## Test plan
- Reset: fill `bank[5]`=8'hAA, assert `reset` one cycle -> `A_Bypass`=`B_Bypass`=8'h00. Reading R5 afterwards gives 8'h00.
- Write then read: `RW_dm`=5'h1f, `mux_ans_dm`=8'h50 for one cycle, then `RA_id`=5'h1f with no forwarding sources -> `A_Bypass`=8'h50 one cycle later.
- R0 protection: `RW_dm`=0, `mux_ans_dm`=8'hFF; `RA_id`=`RB_id`=0 -> both outputs 8'h00.
- Forward priority: `bank[3]`=8'h11, `RW_dm`=3 with `mux_ans_dm`=8'h22, `RW_ex`=3 with `ans_ex`=8'h05, `load_ex`=0, `RA_id`=3 -> `A_Bypass`=8'h05. With `RW_ex`=0 instead -> 8'h22.
- Load-use: `load_ex`=1, `RW_ex`=7, `RB_id`=7 -> `hazard_id`=1 and outputs hold. Next cycle `load_ex`=0, `RW_dm`=7, `mux_ans_dm`=8'h3C -> `B_Bypass`=8'h3C.
- Stall: `stall_id`=1 for 2 cycles while `RW_dm`=4 writes 8'h99 -> outputs frozen. After release, reading R4 gives 8'h99.
